note_matcher: RTL and testbench
===============================

// Module: note_matcher
// PURPOSE
//  Drives the scorer's match interface (en pulse + 16-bit dt, 10 ms units).
//  Keeps a 10 ms song clock, holds one pending chart note (valid/ready from
//  the chart reader) and compares it with rising edges of one fret button.
//  It reports a hit with its timing error, or a miss when the window expires.
//  Stray presses are flagged as ghost presses.
// PARAMETERS
//  TICK_DIV  1_000_000  clk cycles per 10 ms song tick (100 MHz clk)
//  WINDOW    100        hit window in ticks; a hit needs |dt| < WINDOW
// PORTS
//  clk         in   1   100 MHz clock
//  reset       in   1   asynchronous, active-high reset
//  run         in   1   1 = song clock advances; 0 = song clock frozen
//  btn         in   1   fret button level, already synchronised and debounced
//  note_valid  in   1   chart offers a note
//  note_time   in   16  target time of the offered note, in ticks
//  note_ready  out  1   matcher accepts a note (transfer = valid & ready)
//  en          out  1   one-cycle pulse: note matched
//  dt          out  16  |song_time - note_time| of the last hit
//  miss        out  1   one-cycle pulse: note expired without a hit
//  ghost       out  1   one-cycle pulse: press matched no note
//  song_time   out  16  current song time, in ticks
// BEHAVIOUR
//  Reset values: all outputs 0, prescaler 0, btn_q 0, FSM in EMPTY.
//   note_ready reads 1 from the first clk edge after reset is released.
//  Reset mid-operation discards the held note. No miss pulse is produced.
//  Prescaler: counts 0..TICK_DIV-1 while run=1.
//   song_time increments when the prescaler wraps.
//   song_time saturates at 16'hFFFF and never wraps.
//   While run=0, prescaler and song_time hold.
//  Press detect: btn_q is btn registered; press = btn & ~btn_q.
//   A held button gives exactly one press.
//  Combinational terms used in ARMED:
//   diff = |song_time - t| (16 bit); late = song_time > t.
//  FSM states:
//   EMPTY: note_ready=1.
//    note_valid -> latch t=note_time, go to ARMED.
//    A press in EMPTY gives ghost.
//    Valid and press in the same cycle: the press is ghost, the note is latched.
//   ARMED: note_ready=0. Rules, evaluated in order:
//    1. late & diff>=WINDOW -> miss, go to EMPTY.
//       A press in this same cycle is absorbed (no ghost).
//    2. press & diff<WINDOW -> en, dt<=diff, go to EMPTY. Early and late are both allowed.
//    3. press & diff>=WINDOW (early) -> ghost, stay in ARMED.
//  Latency: en, miss and ghost are registered.
//   They go high for exactly 1 cycle, on the cycle after the deciding edge.
//   Back-to-back pulses are allowed.
//  dt updates only together with en and holds until the next hit.
//   Reset value of dt is 0.
//  en, miss and ghost are mutually exclusive in any cycle.
//  At most one note is held. A new note is accepted no earlier than the
//   cycle after the held note resolves.
//  Hits and expiry use the run-frozen song_time.
//   While paused, presses are still judged; no expiry occurs.
// TESTING  (TICK_DIV=4, WINDOW=100)
//  1. Reset, run=1, note t=200 accepted; press at song_time 195
//     -> en for 1 cycle, dt=5, note_ready=1 on the next cycle.
//  2. Note t=200, press at song_time 250 -> en, dt=50.
//     Press at song_time 350 -> no en, miss at song_time 300, ghost=0.
//  3. Note t=500, press at song_time 300 -> ghost, stays ARMED.
//     Press again at song_time 450 -> en, dt=50.
//  4. btn held high 1000 cycles over a note at t=100 -> exactly one en.
//     No second press is detected until btn has gone low.
//  5. run=0 at song_time 120 with note t=100 held 10k cycles -> song_time=120, no miss.
//     run=1 -> miss once song_time=200.
//  6. Assert reset while ARMED -> all outputs 0, no miss.
//     After release, note_ready=1; song_time then saturates at 16'hFFFF with run=1.

Source files
------------

// File: rtl/note_matcher_if.sv
// Signal bundle between the note matcher, the chart reader, the fret button and the scorer.
// The master side drives song control, the button and chart notes; the slave side is the matcher.
interface note_matcher_if;
    logic        run;
    logic        btn;
    logic        note_valid;
    logic [15:0] note_time;
    logic        note_ready;
    logic        en;
    logic [15:0] dt;
    logic        miss;
    logic        ghost;
    logic [15:0] song_time;

    modport master (
        output run, btn, note_valid, note_time,
        input  note_ready, en, dt, miss, ghost, song_time
    );

    modport slave (
        input  run, btn, note_valid, note_time,
        output note_ready, en, dt, miss, ghost, song_time
    );
endinterface

// File: rtl/note_matcher.sv
// Song clock plus a single-note judge: matches button presses against one held chart note
// and emits registered hit (en + dt), miss and ghost pulses.
module note_matcher #(
    parameter int TICK_DIV = 1_000_000,
    parameter int WINDOW   = 100
) (
    input  logic           clk,
    input  logic           reset,
    note_matcher_if.slave  m
);
    localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]     WIN      = 16'(WINDOW);

    typedef enum logic {EMPTY, ARMED} state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic          btn_q;
    logic [15:0]   t;

    logic          press;
    logic          late;
    logic          in_window;
    logic          expired;
    logic [15:0]   diff;

    // Expiry is suppressed while paused so a frozen song never times out a note.
    always_comb begin
        press     = m.btn & ~btn_q;
        late      = m.song_time > t;
        diff      = late ? (m.song_time - t) : (t - m.song_time);
        in_window = diff < WIN;
        expired   = late & ~in_window & m.run;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= EMPTY;
            pre          <= '0;
            btn_q        <= 1'b0;
            t            <= '0;
            m.note_ready <= 1'b0;
            m.en         <= 1'b0;
            m.dt         <= '0;
            m.miss       <= 1'b0;
            m.ghost      <= 1'b0;
            m.song_time  <= '0;
        end else begin
            // NOTE: every register here uses <= so all branches see the pre-edge values.
            btn_q   <= m.btn;
            m.en    <= 1'b0;
            m.miss  <= 1'b0;
            m.ghost <= 1'b0;

            if (m.run) begin
                if (pre == PRE_LAST) begin
                    pre <= '0;
                    if (m.song_time != 16'hFFFF)
                        m.song_time <= m.song_time + 16'd1;
                end else begin
                    pre <= pre + 1'b1;
                end
            end

            case (state)
                EMPTY: begin
                    m.note_ready <= 1'b1;
                    if (press)
                        m.ghost <= 1'b1;
                    if (m.note_valid && m.note_ready) begin
                        t            <= m.note_time;
                        state        <= ARMED;
                        m.note_ready <= 1'b0;
                    end
                end
                ARMED: begin
                    // Priority: expiry swallows a same-cycle press, then hit, then early ghost.
                    if (expired) begin
                        m.miss       <= 1'b1;
                        state        <= EMPTY;
                        m.note_ready <= 1'b1;
                    end else if (press && in_window) begin
                        m.en         <= 1'b1;
                        m.dt         <= diff;
                        state        <= EMPTY;
                        m.note_ready <= 1'b1;
                    end else if (press) begin
                        m.ghost      <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_note_matcher.sv
// Directed bench for note_matcher: table of single-press judgements plus hand sequences
// for expiry, held buttons, pause, reset mid-note and song-clock saturation.
module tb_note_matcher;
    logic clk = 1'b0;
    logic reset;
    logic sat_reset;
    int   total = 0;
    int   bad   = 0;
    bit   sat_done = 1'b0;

    always #5 clk = ~clk;

    note_matcher_if nmi ();
    note_matcher_if sati ();

    note_matcher #(.TICK_DIV(4), .WINDOW(100)) dut (
        .clk   (clk),
        .reset (reset),
        .m     (nmi)
    );

    // Fast song clock so 16'hFFFF is reachable within the cycle budget.
    note_matcher #(.TICK_DIV(1), .WINDOW(100)) sat_dut (
        .clk   (clk),
        .reset (sat_reset),
        .m     (sati)
    );

    typedef struct {
        logic [15:0] t;
        logic [15:0] at;
        logic        en;
        logic        ghost;
        logic [15:0] dt;
        logic        ready;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        nmi.btn        = 1'b0;
        nmi.note_valid = 1'b0;
        nmi.note_time  = '0;
        nmi.run        = 1'b1;
        step();
        step();
        check("reset pulses", {nmi.en, nmi.miss, nmi.ghost, nmi.note_ready}, 0);
        check("reset dt", nmi.dt, 0);
        check("reset song_time", nmi.song_time, 0);
        reset = 1'b0;
        step();
        check("ready after reset", nmi.note_ready, 1);
    endtask

    task automatic offer(input logic [15:0] t);
        bit done = 1'b0;
        nmi.note_time  = t;
        nmi.note_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (nmi.note_ready) begin
                step();
                done = 1'b1;
                break;
            end
            step();
        end
        nmi.note_valid = 1'b0;
        if (!done) timeout("offer");
        else check("armed after accept", nmi.note_ready, 0);
    endtask

    task automatic wait_song(input logic [15:0] x);
        bit done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (nmi.song_time == x) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) timeout("wait_song");
    endtask

    task automatic press();
        nmi.btn = 1'b1;
        step();
        nmi.btn = 1'b0;
    endtask

    task automatic wait_miss(input int bound, output int en_cnt);
        bit done = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            en_cnt += int'(nmi.en);
            if (nmi.miss) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("wait_miss");
    endtask

    initial begin
        sat_reset       = 1'b1;
        sati.run        = 1'b0;
        sati.btn        = 1'b0;
        sati.note_valid = 1'b0;
        sati.note_time  = '0;
        repeat (2) @(posedge clk);
        #1;
        sat_reset = 1'b0;
        sati.run  = 1'b1;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 70000; i++) begin
                @(posedge clk);
                #1;
                if (sati.song_time == 16'hFFFF) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) timeout("saturate");
        end
        repeat (20) @(posedge clk);
        #1;
        check("song_time saturated", sati.song_time, 16'hFFFF);
        check("sat quiet", {sati.en, sati.miss, sati.ghost}, 0);
        sat_done = 1'b1;
    end

    initial begin
        vec_t vecs[6];
        int   en_cnt;
        int   ghost_cnt;
        int   miss_cnt;

        vecs[0] = '{16'd200, 16'd195, 1'b1, 1'b0, 16'd5,  1'b1};
        vecs[1] = '{16'd200, 16'd250, 1'b1, 1'b0, 16'd50, 1'b1};
        vecs[2] = '{16'd200, 16'd101, 1'b1, 1'b0, 16'd99, 1'b1};
        vecs[3] = '{16'd200, 16'd299, 1'b1, 1'b0, 16'd99, 1'b1};
        vecs[4] = '{16'd200, 16'd200, 1'b1, 1'b0, 16'd0,  1'b1};
        vecs[5] = '{16'd200, 16'd100, 1'b0, 1'b1, 16'd0,  1'b0};

        reset          = 1'b1;
        nmi.run        = 1'b0;
        nmi.btn        = 1'b0;
        nmi.note_valid = 1'b0;
        nmi.note_time  = '0;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            offer(vecs[i].t);
            wait_song(vecs[i].at);
            press();
            check($sformatf("v%0d en", i), nmi.en, vecs[i].en);
            check($sformatf("v%0d ghost", i), nmi.ghost, vecs[i].ghost);
            check($sformatf("v%0d miss", i), nmi.miss, 0);
            check($sformatf("v%0d dt", i), nmi.dt, vecs[i].dt);
            check($sformatf("v%0d ready", i), nmi.note_ready, vecs[i].ready);
            step();
            check($sformatf("v%0d pulse width", i), {nmi.en, nmi.ghost}, 0);
        end

        // Unanswered note expires at 300; a later press never produces a hit.
        do_reset();
        offer(16'd200);
        wait_miss(2000, en_cnt);
        check("expire no en", en_cnt, 0);
        check("miss song_time", nmi.song_time, 300);
        check("miss ghost", nmi.ghost, 0);
        wait_song(16'd350);
        press();
        check("late press en", nmi.en, 0);
        check("late press miss", nmi.miss, 0);

        // Early press is a ghost but keeps the note armed for a later hit.
        do_reset();
        offer(16'd500);
        wait_song(16'd300);
        press();
        check("early ghost", nmi.ghost, 1);
        check("early stays armed", nmi.note_ready, 0);
        wait_song(16'd450);
        press();
        check("second press en", nmi.en, 1);
        check("second press dt", nmi.dt, 50);

        // Held button yields exactly one press until released.
        do_reset();
        offer(16'd100);
        wait_song(16'd95);
        nmi.btn   = 1'b1;
        en_cnt    = 0;
        ghost_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            en_cnt    += int'(nmi.en);
            ghost_cnt += int'(nmi.ghost);
        end
        check("held en count", en_cnt, 1);
        check("held ghost count", ghost_cnt, 0);
        check("held dt", nmi.dt, 5);
        offer(16'd360);
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            en_cnt += int'(nmi.en);
        end
        check("still held no en", en_cnt, 0);
        nmi.btn = 1'b0;
        step();
        wait_song(16'd358);
        press();
        check("re-press en", nmi.en, 1);
        check("re-press dt", nmi.dt, 2);

        // Paused song: no expiry, song_time frozen; presses still judged.
        do_reset();
        offer(16'd100);
        wait_song(16'd120);
        nmi.run  = 1'b0;
        miss_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            miss_cnt += int'(nmi.miss);
        end
        check("paused miss count", miss_cnt, 0);
        check("paused song_time", nmi.song_time, 120);
        nmi.run = 1'b1;
        wait_miss(1000, en_cnt);
        check("resume miss song_time", nmi.song_time, 200);
        nmi.run = 1'b0;
        offer(16'd210);
        press();
        check("paused hit en", nmi.en, 1);
        check("paused hit dt", nmi.dt, 10);
        nmi.run = 1'b1;

        // Press on the expiry cycle is absorbed by the miss.
        do_reset();
        offer(16'd100);
        wait_song(16'd200);
        press();
        check("absorb miss", nmi.miss, 1);
        check("absorb ghost", nmi.ghost, 0);
        check("absorb en", nmi.en, 0);
        step();
        check("absorb ghost later", nmi.ghost, 0);
        check("absorb ready", nmi.note_ready, 1);

        // Reset while armed clears everything without a miss.
        do_reset();
        offer(16'd50);
        repeat (10) step();
        #2;
        reset = 1'b1;
        #1;
        check("mid reset pulses", {nmi.en, nmi.miss, nmi.ghost, nmi.note_ready}, 0);
        check("mid reset song_time", nmi.song_time, 0);
        miss_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            miss_cnt += int'(nmi.miss);
        end
        reset = 1'b0;
        step();
        miss_cnt += int'(nmi.miss);
        check("mid reset no miss", miss_cnt, 0);
        check("mid reset ready", nmi.note_ready, 1);

        begin
            bit ok = 1'b0;
            for (int i = 0; i < 80000; i++) begin
                if (sat_done) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            if (!ok) timeout("saturation process");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
